// File: rtl/dcache_miss_ctrl.sv
// Miss/write-through controller beside a direct-mapped data cache: stalls on load
// misses and stores, runs the memory handshake, refills the cache, and tracks errors.
module dcache_miss_ctrl #(
    parameter int INDEX_W = 3,
    parameter int TAG_W   = 27,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               acc_valid_i,
    input  logic [1:0]         acc_we_i,
    input  logic [31:0]        acc_addr_i,
    input  logic [31:0]        acc_wdata_i,
    input  logic               cache_hit_i,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [31:0]        mem_addr_o,
    output logic [3:0]         mem_be_o,
    output logic [31:0]        mem_wdata_o,
    input  logic               mem_ack_i,
    input  logic [31:0]        mem_rdata_i,
    output logic               fill_valid_o,
    output logic [INDEX_W-1:0] fill_index_o,
    output logic [TAG_W-1:0]   fill_tag_o,
    output logic [31:0]        fill_data_o,
    output logic               stall_o,
    output logic               err_o,
    output logic [15:0]        miss_cnt_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        FILL    = 2'd2,
        WR_WAIT = 2'd3
    } state_t;

    // Last wait cycle in which an ack still completes normally.
    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  tmo_cnt_q;
    logic [15:0] miss_cnt_q, miss_cnt_d;
    logic        load_miss, store;
    logic        start_rd, start_wr, rd_done, abort, waiting;

    assign load_miss  = acc_valid_i & ~acc_we_i[0] & ~cache_hit_i;
    assign store      = acc_valid_i & acc_we_i[0];
    assign waiting    = (state_q == RD_WAIT) || (state_q == WR_WAIT);
    assign stall_o    = ~rst & ((state_q != IDLE) | load_miss | store);
    assign miss_cnt_o = miss_cnt_q;

    always_comb begin
        state_d    = state_q;
        start_rd   = 1'b0;
        start_wr   = 1'b0;
        rd_done    = 1'b0;
        abort      = 1'b0;
        miss_cnt_d = miss_cnt_q;
        case (state_q)
            IDLE: begin
                if (load_miss) begin
                    state_d  = RD_WAIT;
                    start_rd = 1'b1;
                end else if (store) begin
                    state_d  = WR_WAIT;
                    start_wr = 1'b1;
                end
            end
            RD_WAIT: begin
                if (mem_ack_i) begin
                    state_d = FILL;
                    rd_done = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            FILL: state_d = IDLE;
            WR_WAIT: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d = IDLE;
                    abort   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (start_rd && (miss_cnt_q != 16'hFFFF)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            tmo_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            err_o        <= 1'b0;
            mem_req_o    <= 1'b0;
            mem_we_o     <= 1'b0;
            mem_addr_o   <= '0;
            mem_be_o     <= '0;
            mem_wdata_o  <= '0;
            fill_valid_o <= 1'b0;
            fill_index_o <= '0;
            fill_tag_o   <= '0;
            fill_data_o  <= '0;
        end else begin
            state_q      <= state_d;
            miss_cnt_q   <= miss_cnt_d;
            mem_req_o    <= (state_d == RD_WAIT) || (state_d == WR_WAIT);
            fill_valid_o <= rd_done;
            if (abort) err_o <= 1'b1;

            if (start_rd || start_wr) begin
                tmo_cnt_q <= '0;
            end else if (waiting && !mem_ack_i) begin
                tmo_cnt_q <= tmo_cnt_q + 8'd1;
            end

            if (start_rd) begin
                mem_addr_o <= {acc_addr_i[31:2], 2'b00};
                mem_we_o   <= 1'b0;
            end
            if (start_wr) begin
                mem_addr_o <= {acc_addr_i[31:2], 2'b00};
                mem_we_o   <= 1'b1;
                // acc_we_i[1] separates sb from sw; sb replicates the byte on all lanes.
                if (acc_we_i[1]) begin
                    mem_be_o    <= 4'b0001 << acc_addr_i[1:0];
                    mem_wdata_o <= {4{acc_wdata_i[7:0]}};
                end else begin
                    mem_be_o    <= 4'b1111;
                    mem_wdata_o <= acc_wdata_i;
                end
            end
            if (rd_done) begin
                fill_data_o  <= mem_rdata_i;
                fill_index_o <= mem_addr_o[INDEX_W+1:2];
                fill_tag_o   <= mem_addr_o[31:INDEX_W+2];
            end
        end
    end

endmodule

// File: doc/dcache_miss_ctrl.md
Name: dcache_miss_ctrl

Overview:
- Memory-stage controller sitting directly beside the direct-mapped data cache (8 sets, 27-bit tag, 32-bit word) and in front of the slow data memory.
- Detects load misses and stalls the pipeline. Fetches the missing word over a req/ack memory handshake, then drives a one-cycle refill into the cache.
- Issues all stores write-through to memory, stalling until the memory acknowledges.
- Reports a sticky timeout error and a saturating miss counter.

Parameters:
- INDEX_W, 3, set index width (address bits [INDEX_W+1:2])
- TAG_W, 27, tag width (address bits [31:INDEX_W+2]); must satisfy TAG_W + INDEX_W + 2 = 32
- TIMEOUT, 255, maximum cycles spent waiting for mem_ack_i before abort (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- acc_valid_i  in  1  memory-stage access present this cycle
- acc_we_i  in  2  access type, same encoding as cache WE: 00 lw, 01 sw, 10 lb, 11 sb
- acc_addr_i  in  32  byte address of the access
- acc_wdata_i  in  32  store data (sb uses [7:0])
- cache_hit_i  in  1  hit flag from the cache for acc_addr_i
- mem_req_o  out  1  memory request, held until ack
- mem_we_o  out  1  1 = write request, 0 = read request
- mem_addr_o  out  32  word-aligned address (low 2 bits forced to 00)
- mem_be_o  out  4  byte enables for writes
- mem_wdata_o  out  32  write data
- mem_ack_i  in  1  memory completion; qualified only while mem_req_o=1
- mem_rdata_i  in  32  read word, valid with mem_ack_i on read requests
- fill_valid_o  out  1  one-cycle refill strobe to the cache
- fill_index_o  out  INDEX_W  set to refill
- fill_tag_o  out  TAG_W  tag to install
- fill_data_o  out  32  word to install
- stall_o  out  1  freeze pipeline (memory stage and earlier)
- err_o  out  1  sticky memory timeout
- miss_cnt_o  out  16  saturating count of load misses

Behaviour:
- Reset (synchronous, highest priority, including mid-transaction):
  - State IDLE.
  - mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0.
  - fill_valid_o=0, fill_index_o=0, fill_tag_o=0, fill_data_o=0.
  - err_o=0, miss_cnt_o=0, timeout counter=0.
  - stall_o=0 in the reset cycle and after. Any in-flight request is abandoned; a late mem_ack_i is ignored.
- Load miss definition: acc_valid_i & ~acc_we_i[0] & ~cache_hit_i.
- Store definition: acc_valid_i & acc_we_i[0].
- States: IDLE, RD_WAIT, FILL, WR_WAIT.
- IDLE:
  - Load miss -> RD_WAIT. Register mem_addr_o={addr[31:2],2'b00}, mem_we_o=0. miss_cnt_o += 1, saturating at 16'hFFFF.
  - Store -> WR_WAIT. Register address as above and mem_we_o=1.
    - sw: mem_be_o=4'b1111, mem_wdata_o=acc_wdata_i.
    - sb: mem_be_o=4'b0001<<addr[1:0], mem_wdata_o={4{acc_wdata_i[7:0]}}.
  - Load hit or no access: stay in IDLE.
  - mem_ack_i is ignored in IDLE.
- stall_o is combinational: 1 when state!=IDLE, or when in IDLE with a load miss or store present. The first stalled cycle is therefore the detection cycle.
- mem_req_o is registered: 1 in RD_WAIT and WR_WAIT, 0 otherwise. Address, data and enables stay stable while mem_req_o=1.
- RD_WAIT:
  - On mem_ack_i: latch mem_rdata_i into fill_data_o, fill_index_o=addr[INDEX_W+1:2], fill_tag_o=addr[31:INDEX_W+2]; go to FILL.
  - An ack in the first RD_WAIT cycle is legal (1-cycle memory).
- FILL:
  - fill_valid_o=1 for exactly this cycle; stall_o=1.
  - Next state IDLE. In that cycle the replayed access hits and stall_o drops, giving load-miss latency of memory latency + 2 stall cycles.
- WR_WAIT: on mem_ack_i go to IDLE; stall_o drops in the IDLE cycle unless a new store or miss is present.
- Timeout:
  - Counter clears on entry to RD_WAIT/WR_WAIT and increments each cycle without ack.
  - When it reaches TIMEOUT: set err_o=1, return to IDLE, mem_req_o=0, no fill. The pipeline resumes with stale data; err_o stays set until reset.
  - An ack arriving in the same cycle the counter reaches TIMEOUT wins: normal completion, no error.
- Store to a set: no fill strobe. The cache updates itself on write hit/miss.
- acc_* inputs are ignored outside IDLE; the pipeline holds them stable while stalled.
- miss_cnt_o counts load misses only, never stores; saturates without wrap.

Test Plan:
- Load miss, 1-cycle memory: lw 0x0000_0044, hit=0, ack next cycle with rdata=0xDEAD_BEEF -> mem_addr_o=0x44, fill_valid_o pulse with index=1, tag=0x2, data=0xDEADBEEF; stall_o high exactly 3 cycles; miss_cnt_o=1.
- sb to 0x0000_0013, wdata=0x0000_00A5, 4-cycle memory -> mem_we_o=1, mem_addr_o=0x10, mem_be_o=4'b1000, mem_wdata_o=0xA5A5A5A5; stall held until ack; no fill_valid_o.
- Load hit lw 0x20 with hit=1 -> stall_o=0, mem_req_o never asserted, miss_cnt_o unchanged.
- Timeout: TIMEOUT=8, read miss, ack never arrives -> after 8 wait cycles err_o=1, mem_req_o=0, state IDLE, no fill; later ack ignored.
- Reset mid-RD_WAIT: assert rst for 1 cycle -> next cycle all outputs 0, stall_o=0; ack arriving afterwards produces no fill.
- Counter saturation: preload via 65536 misses (or forced start at 16'hFFFE) -> miss_cnt_o holds 16'hFFFF after further misses.
